// File: rtl/sub_serial_if.sv
// Handshake/result bundle for the bit-serial subtractor.
// The requester (master) drives start and the operands; the subtractor
// (slave) returns busy, the done pulse and the widened difference.
interface sub_serial_if #(
    parameter int DATA_WIDTH = 4
) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH:0]   sub_result;

    modport master (
        output start, A, B,
        input  busy, done, sub_result
    );

    modport slave (
        input  start, A, B,
        output busy, done, sub_result
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: A - B, one bit per clock, LSB first.
// The result is widened by one bit; the final borrow is the sign bit.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; last result held on sub_result
// SHIFT | one difference bit per edge, DATA_WIDTH edges in total
// DONE  | result published, done high for this single cycle
module sub_serial #(
    parameter int DATA_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sub_serial_if.slave bus
);

    // Counter must reach DATA_WIDTH-1 without wrapping; keep at least one bit.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a_sr;
    logic [DATA_WIDTH-1:0] b_sr;
    logic [DATA_WIDTH-1:0] res_sr;
    logic                  borrow;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH:0]   result_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  diff_bit;
    logic                  borrow_nxt;
    logic [DATA_WIDTH-1:0] res_nxt;

    // One full-subtractor slice on the current LSBs; the new bit enters the
    // result register from the MSB side so after DATA_WIDTH shifts bit 0 is
    // the first one computed.
    always_comb begin
        diff_bit   = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
        res_nxt    = res_sr >> 1;
        res_nxt[DATA_WIDTH-1] = diff_bit;
    end

    // Control FSM with registered busy/done and the published result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.A;
                        b_sr   <= bus.B;
                        res_sr <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        // Final borrow doubles as the sign of the widened result.
                        result_q <= {borrow_nxt, res_nxt};
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sub_result = result_q;

endmodule

// File: doc/sub_serial.md
SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand width in bits; legal values >= 1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled on clk.
REQ-005 SHALL have port A  input  DATA_WIDTH  unsigned minuend; sampled only when start is accepted.
REQ-006 SHALL have port B  input  DATA_WIDTH  unsigned subtrahend; sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse marking sub_result valid.
REQ-009 SHALL have port sub_result  output  DATA_WIDTH+1  A-B as (DATA_WIDTH+1)-bit two's complement.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; encoding is an implementation choice.
REQ-011 In IDLE with start=1 at an edge: SHALL capture A and B into internal shift registers, clear borrow to 0, clear bit counter to 0, and move to SHIFT.
REQ-012 In IDLE with start=0: SHALL remain in IDLE and hold sub_result unchanged.
REQ-013 In SHIFT, each edge: SHALL compute one difference bit = a0 XOR b0 XOR borrow, borrow_next = (~a0 & b0) | (~(a0 XOR b0) & borrow), LSB first, and shift that bit into the result register from the MSB side.
REQ-014 SHALL process exactly DATA_WIDTH bits; on the edge processing bit DATA_WIDTH-1, SHALL move to DONE.
REQ-015 On entering DONE: sub_result[DATA_WIDTH-1:0] SHALL hold the difference bits and sub_result[DATA_WIDTH] SHALL hold the final borrow (equal to sign bit, since A-B >= -(2^DATA_WIDTH-1)).
REQ-016 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL unconditionally return to IDLE next edge.
REQ-017 Latency: start accepted at edge k -> done=1 during the cycle following edge k+DATA_WIDTH (DATA_WIDTH+1 cycles start-to-done).
REQ-018 sub_result SHALL update only at the transition into DONE, and SHALL hold its value from then until the next completed operation or reset; intermediate shift state is internal.
REQ-019 start SHALL be ignored in SHIFT and DONE; A/B changes after acceptance SHALL not affect the result.
REQ-020 Back-to-back: start held high continuously SHALL yield a new acceptance in the IDLE cycle after each DONE (throughput one result per DATA_WIDTH+2 cycles).
REQ-021 Bit counter SHALL be wide enough to count to DATA_WIDTH-1 without wrap; DATA_WIDTH=1 SHALL take one SHIFT cycle.
REQ-022 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.

Reset
REQ-023 When rst_n=0 at an edge: state SHALL go to IDLE, busy=0, done=0, sub_result=0, borrow, counter and shift registers SHALL clear, regardless of state.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; start sampled on the same edge as rst_n=0 SHALL be ignored.
REQ-025 First operation SHALL be accepted on the first edge where rst_n=1 and start=1.

Verification (DATA_WIDTH=4)
REQ-026 A=9, B=3, start one cycle -> done pulses 5 cycles later, sub_result=5'b00110, busy high 5 cycles.
REQ-027 A=3, B=9 -> sub_result=5'b11010 (-6); A=0, B=15 -> 5'b10001 (-15); A=15, B=15 -> 5'b00000.
REQ-028 Start A=9,B=3 then pulse start with A=1,B=2 during SHIFT -> second start ignored, result 5'b00110, single done pulse.
REQ-029 rst_n low for one cycle two edges after start -> busy=0, done never pulses, sub_result=0; next start A=7,B=2 -> 5'b00101.
REQ-030 start held high across two operations (A=5,B=1 then A=1,B=5) -> done pulses 6 cycles apart, results 5'b00100 then 5'b11100.
REQ-031 Random sweep of all 256 (A,B) pairs -> sub_result equals (A-B) mod 32 for every pair.
